char_pattern_decoder: RTL and testbench



---
 rtl/char_pattern_pkg.sv | 43 ++++
 rtl/digit_sync_edge.sv | 32 +++
 rtl/char_pattern_decoder.sv | 199 +++++++++++++++++++
 tb/tb_char_pattern_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_pattern_pkg.sv
// Shared definitions for the character pattern decoder: character codes,
// expected high-phase snapshots, FSM encoding and the reference-line index.
package char_pattern_pkg;

    localparam logic [1:0] CHAR_A = 2'b00;
    localparam logic [1:0] CHAR_J = 2'b01;
    localparam logic [1:0] CHAR_N = 2'b10;
    localparam logic [1:0] CHAR_X = 2'b11;

    localparam logic [15:0] PAT_A = 16'h9F8F;
    localparam logic [15:0] PAT_J = 16'h6998;
    localparam logic [15:0] PAT_N = 16'h9DA9;
    localparam logic [15:0] PAT_X = 16'h9679;

    localparam int REF_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } match_t;

    function automatic match_t match_pattern(input logic [15:0] hi);
        match_t m;
        m.hit  = 1'b1;
        m.code = CHAR_A;
        case (hi)
            PAT_A:   m.code = CHAR_A;
            PAT_J:   m.code = CHAR_J;
            PAT_N:   m.code = CHAR_N;
            PAT_X:   m.code = CHAR_X;
            default: m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/digit_sync_edge.sv
// Multi-stage synchronizer for the digit bus plus rise/fall detection on the
// reference line. Data flops are deliberately unreset so a reset never fakes an edge.
module digit_sync_edge
    import char_pattern_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 16,
    parameter int REF_IDX     = REF_BIT
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] digit_i,
    output logic [WIDTH-1:0] bus_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic             ref_d_q;

    always_ff @(posedge clk) begin
        sync_q[0] <= digit_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        ref_d_q <= sync_q[SYNC_STAGES-1][REF_IDX];
    end

    assign bus_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = bus_o[REF_IDX] & ~ref_d_q;
    assign fall_o = ~bus_o[REF_IDX] & ref_d_q;

endmodule

// File: rtl/char_pattern_decoder.sv
// Decodes the 16-line spike-pattern bus into A/J/N/X tokens with a ready/valid
// handshake. Optional ref-period measurement is enabled by CHAR_DEC_PERIOD_MEAS_EN.
module char_pattern_decoder
    import char_pattern_pkg::*;
#(
    parameter int STABLE_PERIODS = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] digit_in,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [1:0]  char_code,
    output logic        char_err,
    output logic        overrun,
    output logic        lock,
    output logic [31:0] period_cycles
);

    localparam logic [3:0]  STABLE_TGT = 4'(STABLE_PERIODS);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

    logic [15:0] bus_s;
    logic        rise, fall;

    digit_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (16),
        .REF_IDX     (REF_BIT)
    ) u_sync (
        .clk     (clk),
        .digit_i (digit_in),
        .bus_o   (bus_s),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    dec_state_e  state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic        hi_cap_q, hi_cap_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  prev_q, prev_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        lock_q, lock_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic [1:0]  code_q, code_d;
    logic        ovr_q, ovr_d;
    logic        timeout, emit, new_run, per_ok;
    match_t      m;

    assign m       = match_pattern(hi_q);
    assign per_ok  = m.hit && (bus_s == ~hi_q);
    // A zero count doubles as "no previous code", so any valid period starts a run.
    assign new_run = (cnt_q == 4'd0) || (m.code != prev_q);
    assign timeout = (state_q != ST_IDLE) && !rise && !fall && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        hi_cap_d = 1'b0;
        cnt_d    = cnt_q;
        prev_d   = prev_q;
        lock_d   = lock_q;
        err_d    = 1'b0;
        emit     = 1'b0;
        to_cnt_d = (rise || fall) ? 32'd0 : to_cnt_q + 32'd1;

        if (!enable) begin
            state_d  = ST_IDLE;
            lock_d   = 1'b0;
            cnt_d    = 4'd0;
            to_cnt_d = 32'd0;
        end else if (timeout) begin
            state_d  = ST_SEEK;
            lock_d   = 1'b0;
            cnt_d    = 4'd0;
            err_d    = 1'b1;
            to_cnt_d = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SEEK;
                    to_cnt_d = 32'd0;
                end
                ST_SEEK: begin
                    if (rise) begin
                        state_d  = ST_HIGH;
                        hi_cap_d = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (hi_cap_q) hi_d = bus_s;
                    if (fall) state_d = ST_LOW;
                end
                ST_LOW: begin
                    state_d = ST_SEEK;
                    if (per_ok) begin
                        lock_d = 1'b1;
                        if (new_run) begin
                            prev_d = m.code;
                            cnt_d  = 4'd1;
                        end else if (cnt_q != 4'd15) begin
                            cnt_d = cnt_q + 4'd1;
                        end
                        emit = (cnt_d == STABLE_TGT) && (new_run || (cnt_d != cnt_q));
                    end else begin
                        err_d  = 1'b1;
                        cnt_d  = 4'd0;
                        prev_d = CHAR_A;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A decision arriving while the host stalls is dropped and flagged.
    always_comb begin
        valid_d = valid_q & ~char_ready;
        code_d  = code_q;
        ovr_d   = ovr_q;
        if (emit) begin
            if (valid_q && !char_ready) begin
                ovr_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                code_d  = m.code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hi_cap_q <= 1'b0;
            cnt_q    <= 4'd0;
            prev_q   <= CHAR_A;
            to_cnt_q <= 32'd0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= CHAR_A;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_cap_q <= hi_cap_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            to_cnt_q <= to_cnt_d;
            lock_q   <= lock_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

`ifdef CHAR_DEC_PERIOD_MEAS_EN
    logic [31:0] per_cnt_q, per_q;

    // lock implies a rise has restarted per_cnt_q since the last timeout or idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt_q <= 32'd0;
            per_q     <= 32'd0;
        end else begin
            if (rise) begin
                per_cnt_q <= 32'd1;
            end else if (per_cnt_q != 32'hFFFF_FFFF) begin
                per_cnt_q <= per_cnt_q + 32'd1;
            end
            if (enable && timeout) begin
                per_q <= 32'd0;
            end else if (enable && rise && lock_q) begin
                per_q <= per_cnt_q;
            end
        end
    end

    assign period_cycles = per_q;
`else
    assign period_cycles = 32'd0;
`endif

    assign char_valid = valid_q;
    assign char_code  = code_q;
    assign char_err   = err_q;
    assign overrun    = ovr_q;
    assign lock       = lock_q;

endmodule

// File: tb/tb_char_pattern_decoder.sv
// Directed and randomized bench for char_pattern_decoder against a period-level
// model of the decoding, stability and handshake rules.
module tb_char_pattern_decoder;

    localparam int SP = 4;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        char_ready = 1'b0;
    logic [15:0] digit_in = 16'h0000;
    logic        char_valid, char_err, overrun, lock;
    logic [1:0]  char_code;
    logic [31:0] period_cycles;

    int vectors = 0;
    int miscompares = 0;
    int got_q[$];
    int exp_q[$];
    int err_seen = 0;
    int exp_err = 0;
    int run_len = 0;
    int prev_code = -1;
    int pend_code = 0;
    bit pending = 1'b0;
    bit ovr_exp = 1'b0;
    bit lock_exp = 1'b0;

    char_pattern_decoder #(
        .STABLE_PERIODS (SP),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .digit_in      (digit_in),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .char_code     (char_code),
        .char_err      (char_err),
        .overrun       (overrun),
        .lock          (lock),
        .period_cycles (period_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && char_valid && char_ready) got_q.push_back(int'(char_code));
        if (char_err) err_seen++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pat(input int c);
        case (c)
            0:       return 16'h9F8F;
            1:       return 16'h6998;
            2:       return 16'h9DA9;
            default: return 16'h9679;
        endcase
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_phase(input logic [15:0] v, input int n);
        digit_in = v;
        repeat (n) tick();
    endtask

    // One ref period seen at the character level.
    task automatic model_period(input bit valid, input int code);
        if (pending && char_ready) begin
            exp_q.push_back(pend_code);
            pending = 1'b0;
        end
        if (!valid) begin
            exp_err++;
            run_len = 0;
            prev_code = -1;
        end else begin
            lock_exp = 1'b1;
            if (code == prev_code) begin
                run_len++;
            end else begin
                prev_code = code;
                run_len = 1;
            end
            if (run_len == SP) begin
                if (pending) ovr_exp = 1'b1;
                else if (char_ready) exp_q.push_back(code);
                else begin
                    pending = 1'b1;
                    pend_code = code;
                end
            end
        end
    endtask

    task automatic run_period(input int code, input int flip, input bit in_low,
                              input int hl, input int ll);
        logic [15:0] h, l;
        h = pat(code);
        l = ~h;
        if (flip >= 0) begin
            if (in_low) l[flip] = ~l[flip];
            else        h[flip] = ~h[flip];
        end
        drive_phase(h, hl);
        drive_phase(l, ll);
        model_period(flip < 0, code);
    endtask

    task automatic check_tokens(input string tag);
        check({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, ".code"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".errs"}, err_seen, exp_err);
        check({tag, ".lock"}, lock, lock_exp);
        check({tag, ".overrun"}, overrun, ovr_exp);
        check({tag, ".valid"}, char_valid, pending);
        if (pending) check({tag, ".pend_code"}, char_code, pend_code);
    endtask

    initial begin
        int n;
        bit hit;
        int c, len, flip, hl, ll;
        int plen[3];
        longint per_exp;

        repeat (4) tick();
        check("rst.valid", char_valid, 0);
        check("rst.code", char_code, 0);
        check("rst.err", char_err, 0);
        check("rst.overrun", overrun, 0);
        check("rst.lock", lock, 0);
        check("rst.period", period_cycles, 0);

        rst_n = 1'b1;
        enable = 1'b1;
        char_ready = 1'b1;
        repeat (3) tick();

        // N held: one token after the 4th valid period, none afterwards
        for (int i = 0; i < 3; i++) run_period(2, -1, 1'b0, 8, 8);
        check_tokens("n_pre");
        run_period(2, -1, 1'b0, 8, 8);
        check_tokens("n_emit");
        for (int i = 0; i < 4; i++) run_period(2, -1, 1'b0, 8, 8);
        check_tokens("n_hold");
`ifdef CHAR_DEC_PERIOD_MEAS_EN
        per_exp = 16;
`else
        per_exp = 0;
`endif
        check("n.period", period_cycles, per_exp);
        check_state("n");

        // A then X across a clean boundary
        for (int i = 0; i < 6; i++) run_period(0, -1, 1'b0, 8, 8);
        for (int i = 0; i < 6; i++) run_period(3, -1, 1'b0, 8, 8);
        check_tokens("ax");
        check_state("ax");

        // J with bit 9 corrupted in one low phase
        run_period(1, -1, 1'b0, 8, 8);
        run_period(1, -1, 1'b0, 8, 8);
        run_period(1, 9, 1'b1, 8, 8);
        for (int i = 0; i < 3; i++) run_period(1, -1, 1'b0, 8, 8);
        check_tokens("j_pre");
        check_state("j_pre");
        run_period(1, -1, 1'b0, 8, 8);
        check_tokens("j_emit");

        // Backpressure A -> J -> N
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_period(0, -1, 1'b0, 8, 8);
        check_state("bp_a");
        for (int i = 0; i < 4; i++) run_period(1, -1, 1'b0, 8, 8);
        check_state("bp_j");
        char_ready = 1'b1;
        for (int i = 0; i < 4; i++) run_period(2, -1, 1'b0, 8, 8);
        check_tokens("bp");
        check_state("bp_n");

        // Ref line stops: timeout
        drive_phase(pat(2), 8);
        digit_in = ~pat(2);
        model_period(1'b1, 2);
        n = 0;
        hit = 1'b0;
        for (int k = 1; k <= TO + 64; k++) begin
            tick();
            if (char_err) begin
                n = k;
                hit = 1'b1;
                break;
            end
        end
        check("to.fired", hit, 1);
        check("to.latency_in_window", (n >= TO && n <= TO + 8), 1);
        exp_err++;
        lock_exp = 1'b0;
        run_len = 0;
        prev_code = -1;
        repeat (2) tick();
        check("to.period", period_cycles, 0);
        check_state("to");
        run_period(2, -1, 1'b0, 8, 8);
        check("to.relock", lock, 1);
        check_tokens("to");

        // Reset mid-HIGH with a token pending
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_period(0, -1, 1'b0, 8, 8);
        check_state("rs_pre");
        drive_phase(pat(0), 3);
        rst_n = 1'b0;
        tick();
        check("rs.valid", char_valid, 0);
        check("rs.code", char_code, 0);
        check("rs.err", char_err, 0);
        check("rs.overrun", overrun, 0);
        check("rs.lock", lock, 0);
        check("rs.period", period_cycles, 0);
        rst_n = 1'b1;
        pending = 1'b0;
        ovr_exp = 1'b0;
        lock_exp = 1'b0;
        run_len = 0;
        prev_code = -1;
        got_q.delete();
        exp_q.delete();
        char_ready = 1'b1;
        drive_phase(pat(0), 5);
        drive_phase(~pat(0), 8);
        for (int i = 0; i < 3; i++) run_period(0, -1, 1'b0, 8, 8);
        check_tokens("rs_pre_tok");
        run_period(0, -1, 1'b0, 8, 8);
        check_tokens("rs_tok");
        check_state("rs");

        // Randomized runs, corruption and backpressure
        for (int p = 0; p < 60; p++) begin
            c = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            for (int r = 0; r < len; r++) begin
                char_ready = ($urandom_range(0, 3) != 0);
                flip = -1;
                if ($urandom_range(0, 7) == 0) begin
                    flip = $urandom_range(0, 14);
                    if (flip >= 3) flip++;
                end
                run_period(c, flip, 1'($urandom_range(0, 1)),
                           $urandom_range(4, 10), $urandom_range(6, 10));
            end
        end
        char_ready = 1'b1;
        c = $urandom_range(0, 3);
        for (int i = 0; i < 3; i++) begin
            hl = $urandom_range(4, 10);
            ll = $urandom_range(6, 10);
            plen[i] = hl + ll;
            run_period(c, -1, 1'b0, hl, ll);
        end
`ifdef CHAR_DEC_PERIOD_MEAS_EN
        per_exp = plen[1];
`else
        per_exp = 0;
`endif
        check("rnd.period", period_cycles, per_exp);
        check_tokens("rnd");
        check_state("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
